// File: rtl/cla_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_GROUP  = 4;
    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 2;

endpackage

// File: rtl/cla_group4.sv
// 4-bit carry-lookahead group: bit sums plus group generate/propagate and carry-out.
module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_g,
    output logic       grp_p,
    output logic       cout
);

    logic [3:0] bit_g;
    logic [3:0] bit_p;
    logic [3:0] c;

    always_comb begin
        bit_g = a & b;
        bit_p = a ^ b;
        c[0]  = cin;
        c[1]  = bit_g[0] | (bit_p[0] & cin);
        c[2]  = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
        c[3]  = bit_g[2] | (bit_p[2] & bit_g[1]) | (bit_p[2] & bit_p[1] & bit_g[0])
              | (bit_p[2] & bit_p[1] & bit_p[0] & cin);
        grp_g = bit_g[3] | (bit_p[3] & bit_g[2]) | (bit_p[3] & bit_p[2] & bit_g[1])
              | (bit_p[3] & bit_p[2] & bit_p[1] & bit_g[0]);
        grp_p = &bit_p;
        cout  = grp_g | (grp_p & cin);
        sum   = bit_p ^ c;
    end

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined add/subtract: one operand slice per stage, carry registered between stages,
// valid/ready handshake with bubble-collapsing stage loads.
module pipe_cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_In,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             C_Out,
    output logic             ovf
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned NGRP  = SLICE / CLA_GROUP;

    if ((WIDTH % (CLA_GROUP * STAGES)) != 0) begin : g_param_check
        $fatal(1, "pipe_cla_adder: WIDTH must be divisible by 4*STAGES");
    end

    // Stage inputs: operands are kept shifted so the active slice always sits at bit 0.
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ld;
    logic              ovf_q;
    logic              ovf_n;
    logic              cin_msb;

    logic [STAGES-1:0][SLICE-1:0] sl_sum;
    logic [STAGES-1:0]            sl_co;

    always_comb begin
        st_a[0] = A;
        st_b[0] = sub ? ~B : B;
        st_s[0] = '0;
        st_c[0] = sub | C_In;
        st_v[0] = in_valid;
        for (int k = 1; k < int'(STAGES); k++) begin
            st_a[k] = a_q[k-1];
            st_b[k] = b_q[k-1];
            st_s[k] = s_q[k-1];
            st_c[k] = c_q[k-1];
            st_v[k] = v_q[k-1];
        end
    end

    // A stage may load when empty or when its successor is loading this cycle.
    always_comb begin
        ld[STAGES-1] = !v_q[STAGES-1] || out_ready;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            ld[k] = !v_q[k] || ld[k+1];
        end
    end

    assign in_ready = !rst && ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [NGRP:0]   gc;
        logic [NGRP-1:0] gg;
        logic [NGRP-1:0] gp;
        logic [NGRP-1:0] co_unused;

        assign gc[0] = st_c[k];

        for (genvar g = 0; g < NGRP; g++) begin : g_grp
            cla_group4 u_grp (
                .a     (st_a[k][CLA_GROUP*g +: CLA_GROUP]),
                .b     (st_b[k][CLA_GROUP*g +: CLA_GROUP]),
                .cin   (gc[g]),
                .sum   (sl_sum[k][CLA_GROUP*g +: CLA_GROUP]),
                .grp_g (gg[g]),
                .grp_p (gp[g]),
                .cout  (co_unused[g])
            );
            // Group carries come from group generate/propagate rather than rippling bits.
            assign gc[g+1] = gg[g] | (gp[g] & gc[g]);
        end

        assign sl_co[k] = gc[NGRP];
    end

    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    assign cin_msb = sl_sum[STAGES-1][SLICE-1] ^ st_a[STAGES-1][SLICE-1] ^ st_b[STAGES-1][SLICE-1];
    assign ovf_n   = cin_msb ^ sl_co[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ld[k]) begin
                    v_q[k] <= st_v[k];
                    a_q[k] <= st_a[k] >> SLICE;
                    b_q[k] <= st_b[k] >> SLICE;
                    s_q[k] <= (st_s[k] >> SLICE) | (WIDTH'(sl_sum[k]) << (WIDTH - SLICE));
                    c_q[k] <= sl_co[k];
                end
            end
            if (ld[STAGES-1]) begin
                ovf_q <= ovf_n;
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign Sum       = s_q[STAGES-1];
    assign C_Out     = c_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Scoreboard bench for pipe_cla_adder (WIDTH=16, STAGES=2) against an arithmetic model.
module tb_pipe_cla_adder;

    localparam int unsigned W = 16;
    localparam int unsigned S = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_In;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         C_Out;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;

    logic [W+1:0] exp_q [$];

    always #5 clk = ~clk;

    pipe_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .C_In      (C_In),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .C_Out     (C_Out),
        .ovf       (ovf)
    );

    // Reference: unsigned sum for Sum/C_Out, true signed result range for ovf.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        longint ua   = longint'(a);
        longint ub   = longint'(b);
        longint sa   = longint'($signed(a));
        longint sbv  = longint'($signed(b));
        longint mask = (longint'(1) << W) - 1;
        longint lim  = longint'(1) << (W - 1);
        longint total;
        longint sgn;
        logic   ovf_m;
        if (sb) begin
            total = ua + ((~ub) & mask) + 1;
            sgn   = sa - sbv;
        end else begin
            total = ua + ub + longint'(ci);
            sgn   = sa + sbv + longint'(ci);
        end
        ovf_m = (sgn >= lim) || (sgn < -lim);
        return {W'(total), total[W], ovf_m};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; offers one operand set and returns whether it was taken.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sb, output logic acc);
        in_valid = v;
        A        = a;
        B        = b;
        C_In     = ci;
        sub      = sb;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) begin
            exp_q.push_back(model(a, b, ci, sb));
            n_in++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stray_output: got Sum=%h C_Out=%b ovf=%b, expected no output",
                         Sum, C_Out, ovf);
            end else begin
                if ({Sum, C_Out, ovf} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL result_%0d: got Sum=%h C_Out=%b ovf=%b, expected Sum=%h C_Out=%b ovf=%b",
                             n_out, Sum, C_Out, ovf, exp_q[0][W+1:2], exp_q[0][1], exp_q[0][0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    initial begin
        logic acc;
        int   accepted;

        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        C_In      = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(Sum), 32'd0);
        chk("rst_c_out", 32'(C_Out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Wrap-around add and exact two-cycle latency.
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
        chk("accept_single", 32'(acc), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_two", 32'(out_valid), 32'd1);
        chk("wrap_sum", 32'(Sum), 32'h0000);
        chk("wrap_c_out", 32'(C_Out), 32'd1);
        chk("wrap_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;

        // Subtract: signed overflow, then borrow.
        drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, acc);
        drive(1'b1, 16'h0000, 16'h0001, 1'b1, 1'b1, acc);
        in_valid = 1'b0;
        wait_valid("sub_ovf_valid");
        chk("sub_ovf_sum", 32'(Sum), 32'h7FFF);
        chk("sub_ovf_c_out", 32'(C_Out), 32'd1);
        chk("sub_ovf_ovf", 32'(ovf), 32'd1);
        @(negedge clk);
        chk("sub_borrow_valid", 32'(out_valid), 32'd1);
        chk("sub_borrow_sum", 32'(Sum), 32'hFFFF);
        chk("sub_borrow_c_out", 32'(C_Out), 32'd0);
        chk("sub_borrow_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;

        // Backpressure: pipeline fills to capacity, outputs held while stalled.
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), acc);
            accepted += int'(acc);
        end
        chk("stall_accept_count", 32'(accepted), 32'd2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        repeat (2) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);
        out_ready = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, acc);
        chk("full_pipe_accept", 32'(acc), 32'd1);
        drain();
        chk("count_directed", 32'(n_out), 32'(n_in));

        // Reset with two transactions in flight discards them.
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b0, acc);
        drive(1'b1, 16'h0F0F, 16'h00FF, 1'b0, 1'b1, acc);
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        n_in  = 0;
        n_out = 0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        repeat (5) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, acc);

        // Random traffic with random backpressure.
        for (int i = 0; i < 10000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                  1'($urandom), 1'($urandom), acc);
        end
        drain();
        chk("count_in_out", 32'(n_out), 32'(n_in));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
